// File: rtl/layer1_pkg.sv
// Shared constants, FSM state type and fixed-point helpers for the layer-1
// convolution controller and its accumulator lanes.
`ifndef LAYER1_PKG_SV
`define LAYER1_PKG_SV

`define L1_LANE(vec, k, w) vec[(k)*(w) +: (w)]

package layer1_pkg;

    localparam int WORD_W = 16;
    localparam int N_OUT  = 8;
    localparam int KTAPS  = 9;
    localparam int ACC_W  = 20;
    localparam int PIX_W  = 12;

    localparam logic [3:0] TAP_LAST = 4'(KTAPS - 1);

    localparam logic signed [ACC_W:0] SAT_HI = 21'sd32767;
    localparam logic signed [ACC_W:0] SAT_LO = -21'sd32768;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_OUTPUT = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    // Clamp a widened sum into the Q6.10 output range.
    function automatic logic [WORD_W-1:0] sat16(input logic signed [ACC_W:0] val);
        logic [WORD_W-1:0] res;
        if (val > SAT_HI) begin
            res = 16'h7FFF;
        end else if (val < SAT_LO) begin
            res = 16'h8000;
        end else begin
            res = val[WORD_W-1:0];
        end
        return res;
    endfunction

endpackage

`endif

// File: rtl/layer1_conv_ctrl_if.sv
// Tap-input and result-output stream bundle of the layer-1 controller.
interface layer1_conv_ctrl_if;
    import layer1_pkg::*;

    logic                      in_valid;
    logic                      in_ready;
    logic [3*WORD_W-1:0]       in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [N_OUT*WORD_W-1:0]   out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/layer1_acc_sat.sv
// Eight accumulator lanes: per-tap add, clear, and the final
// bias + saturate + optional ReLU load of the output register.
module layer1_acc_sat
    import layer1_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     add,
    input  logic                     fin,
    input  logic                     relu,
    input  logic [N_OUT*WORD_W-1:0]  sa_out,
    input  logic [N_OUT*WORD_W-1:0]  bias,
    output logic [N_OUT*WORD_W-1:0]  out_data
);

    logic signed [ACC_W-1:0] acc_r   [N_OUT];
    logic signed [ACC_W:0]   sum_s   [N_OUT];
    logic [WORD_W-1:0]       sat_s   [N_OUT];
    logic [N_OUT*WORD_W-1:0] result_s;
    logic [N_OUT*WORD_W-1:0] out_data_r;

    // Final-beat value per lane, formed one bit wider than the accumulator
    always_comb begin
        result_s = '0;
        for (int k = 0; k < N_OUT; k++) begin
            sum_s[k] = $signed({acc_r[k][ACC_W-1], acc_r[k]})
                     + $signed({{(ACC_W+1-WORD_W){sa_out[k*WORD_W+WORD_W-1]}}, `L1_LANE(sa_out, k, WORD_W)})
                     + $signed({{(ACC_W+1-WORD_W){bias[k*WORD_W+WORD_W-1]}}, `L1_LANE(bias, k, WORD_W)});
            sat_s[k] = sat16(sum_s[k]);
            if (relu && sat_s[k][WORD_W-1]) begin
                `L1_LANE(result_s, k, WORD_W) = 16'h0000;
            end else begin
                `L1_LANE(result_s, k, WORD_W) = sat_s[k];
            end
        end
    end

    // Accumulator lanes and the held output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_OUT; k++) begin
                acc_r[k] <= '0;
            end
            out_data_r <= '0;
        end else begin
            for (int k = 0; k < N_OUT; k++) begin
                if (clr) begin
                    acc_r[k] <= '0;
                end else if (add) begin
                    acc_r[k] <= acc_r[k]
                              + $signed({{(ACC_W-WORD_W){sa_out[k*WORD_W+WORD_W-1]}}, `L1_LANE(sa_out, k, WORD_W)});
                end else begin
                    acc_r[k] <= acc_r[k];
                end
            end
            if (fin) begin
                out_data_r <= result_s;
            end else begin
                out_data_r <= out_data_r;
            end
        end
    end

    assign out_data = out_data_r;

endmodule

// File: rtl/layer1_conv_ctrl.sv
// Pixel sequencer around the 3-in/8-out MAC array: nine taps per pixel,
// then one handshaked 8-channel result, for a programmed number of pixels.
module layer1_conv_ctrl
    import layer1_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [PIX_W-1:0]              num_pixels,
    input  logic                          relu_en,
    output logic                          busy,
    output logic                          done,
    layer1_conv_ctrl_if.slave             bus,
    output logic [3:0]                    w_addr,
    input  logic [N_OUT*3*WORD_W-1:0]     w_data,
    input  logic [N_OUT*WORD_W-1:0]       bias,
    output logic [3*WORD_W-1:0]           sa_input,
    output logic [N_OUT*3*WORD_W-1:0]     sa_weight,
    input  logic [N_OUT*WORD_W-1:0]       sa_out
);

    state_t             state_r;
    state_t             state_s;
    logic [3:0]         tap_cnt_r;
    logic [PIX_W-1:0]   pix_cnt_r;
    logic [PIX_W-1:0]   num_pix_r;
    logic               relu_r;

    logic               accept_s;
    logic               last_tap_s;
    logic               last_pix_s;
    logic               start_ok_s;
    logic               out_take_s;
    logic               busy_s;
    logic               done_s;
    logic               in_ready_s;
    logic               out_valid_s;
    logic [N_OUT*WORD_W-1:0] out_data_s;

    assign start_ok_s = (state_r == ST_IDLE) && start;
    assign accept_s   = (state_r == ST_ACCUM) && bus.in_valid;
    assign out_take_s = (state_r == ST_OUTPUT) && bus.out_ready;
    assign last_tap_s = (tap_cnt_r == TAP_LAST);
    assign last_pix_s = (pix_cnt_r == (num_pix_r - 12'd1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_ACCUM;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (accept_s && last_tap_s) begin
                    state_s = ST_OUTPUT;
                end else begin
                    state_s = ST_ACCUM;
                end
            end
            ST_OUTPUT: begin
                if (bus.out_ready) begin
                    state_s = last_pix_s ? ST_FINISH : ST_ACCUM;
                end else begin
                    state_s = ST_OUTPUT;
                end
            end
            ST_FINISH: state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the state register
    always_comb begin
        busy_s      = 1'b1;
        done_s      = 1'b0;
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_r)
            ST_IDLE:   busy_s      = 1'b0;
            ST_ACCUM:  in_ready_s  = 1'b1;
            ST_OUTPUT: out_valid_s = 1'b1;
            ST_FINISH: done_s      = 1'b1;
            default:   busy_s      = 1'b0;
        endcase
    end

    // Run parameters and tap/pixel counters; a zero pixel count runs one pixel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_cnt_r <= 4'd0;
            pix_cnt_r <= '0;
            num_pix_r <= '0;
            relu_r    <= 1'b0;
        end else if (start_ok_s) begin
            tap_cnt_r <= 4'd0;
            pix_cnt_r <= '0;
            num_pix_r <= (num_pixels == '0) ? 12'd1 : num_pixels;
            relu_r    <= relu_en;
        end else if (accept_s) begin
            tap_cnt_r <= last_tap_s ? 4'd0 : (tap_cnt_r + 4'd1);
        end else if (out_take_s && !last_pix_s) begin
            pix_cnt_r <= pix_cnt_r + 12'd1;
        end else begin
            tap_cnt_r <= tap_cnt_r;
        end
    end

    layer1_acc_sat u_acc (
        .clk      (clk),
        .rst      (rst),
        .clr      (start_ok_s || out_take_s),
        .add      (accept_s && !last_tap_s),
        .fin      (accept_s && last_tap_s),
        .relu     (relu_r),
        .sa_out   (sa_out),
        .bias     (bias),
        .out_data (out_data_s)
    );

    assign busy          = busy_s;
    assign done          = done_s;
    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.out_data  = out_data_s;
    assign w_addr        = tap_cnt_r;
    assign sa_input      = bus.in_data;
    assign sa_weight     = w_data;

endmodule

// File: tb/tb_layer1_conv_ctrl.sv
// Scoreboard bench for layer1_conv_ctrl with a behavioural MAC array on the
// sa_* ports and a weight table addressed by w_addr.
module tb_layer1_conv_ctrl;
    import layer1_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic relu_en = 1'b0;
    logic [PIX_W-1:0] num_pixels = '0;
    logic busy, done;
    logic [3:0] w_addr;
    logic [N_OUT*3*WORD_W-1:0] w_data, sa_weight;
    logic [N_OUT*WORD_W-1:0]   bias, sa_out;
    logic [3*WORD_W-1:0]       sa_input;

    logic [3*WORD_W-1:0]       tap_in [KTAPS];
    logic [N_OUT*3*WORD_W-1:0] wtab   [KTAPS];
    logic [127:0]              sb_q   [$];
    logic [127:0]              last_out;
    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    layer1_conv_ctrl_if bus();

    always #5 clk = ~clk;

    layer1_conv_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .num_pixels(num_pixels),
        .relu_en(relu_en), .busy(busy), .done(done), .bus(bus),
        .w_addr(w_addr), .w_data(w_data), .bias(bias), .sa_input(sa_input),
        .sa_weight(sa_weight), .sa_out(sa_out)
    );

    // One MAC-array lane: Q6.10 dot product of 3 channels, truncated to 16 bits
    function automatic logic [15:0] sys_lane(input logic [47:0] x, input logic [47:0] w);
        longint s;
        s = 0;
        for (int c = 0; c < 3; c++)
            s += longint'($signed(x[c*16 +: 16])) * longint'($signed(w[c*16 +: 16]));
        s = s >>> 10;
        return s[15:0];
    endfunction

    always_comb begin
        sa_out = '0;
        for (int k = 0; k < N_OUT; k++)
            sa_out[k*16 +: 16] = sys_lane(sa_input, sa_weight[k*48 +: 48]);
    end

    assign w_data = (w_addr < 4'd9) ? wtab[w_addr] : '0;

    always @(negedge clk) if (done) done_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1);
    end

    function automatic logic [127:0] exp_pixel(input logic relu);
        logic [127:0] r;
        longint a;
        r = '0;
        for (int k = 0; k < N_OUT; k++) begin
            a = 0;
            for (int t = 0; t < KTAPS; t++)
                a += longint'($signed(sys_lane(tap_in[t], wtab[t][k*48 +: 48])));
            a += longint'($signed(bias[k*16 +: 16]));
            if (a > 32767) a = 32767;
            if (a < -32768) a = -32768;
            if (relu && a < 0) a = 0;
            r[k*16 +: 16] = a[15:0];
        end
        return r;
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic setup_simple(input logic [15:0] x0, input logic [15:0] w0, input logic [15:0] b0);
        for (int t = 0; t < KTAPS; t++) begin
            tap_in[t] = {16'h0000, 16'h0000, x0};
            wtab[t]   = '0;
            wtab[t][15:0] = w0;
        end
        bias = '0;
        bias[15:0] = b0;
    endtask

    task automatic start_run(input logic [PIX_W-1:0] n, input logic r);
        @(negedge clk);
        start = 1'b1; num_pixels = n; relu_en = r;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drive_pixel(input int gap, input int ntaps);
        int guard;
        for (int t = 0; t < ntaps; t++) begin
            if (gap != 0) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = tap_in[t];
            guard = 0;
            while (!bus.in_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (!bus.in_ready) begin
                check_eq("in_ready_timeout", 128'(bus.in_ready), 128'd1);
                bus.in_valid = 1'b0;
                return;
            end
            check_eq("w_addr", 128'(w_addr), 128'(t));
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic get_output(input int hold, input logic last);
        int guard;
        logic [127:0] snap, exp;
        guard = 0;
        while (!bus.out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_eq("out_valid_wait", 128'(bus.out_valid), 128'd1);
        snap = bus.out_data;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_eq("hold_valid", 128'(bus.out_valid), 128'd1);
            check_eq("hold_data", bus.out_data, snap);
            check_eq("hold_in_ready", 128'(bus.in_ready), 128'd0);
        end
        if (sb_q.size() == 0) begin
            check_eq("sb_empty", 128'd0, 128'd1);
            exp = '0;
        end else begin
            exp = sb_q.pop_front();
        end
        check_eq("pixel", bus.out_data, exp);
        last_out = bus.out_data;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_eq("done_after_hs", 128'(done), 128'(last));
        check_eq("valid_drop", 128'(bus.out_valid), 128'd0);
        if (last) begin
            @(negedge clk);
            check_eq("done_pulse_end", 128'(done), 128'd0);
            check_eq("idle_busy", 128'(busy), 128'd0);
        end
    endtask

    task automatic single_pixel(input logic [PIX_W-1:0] n, input logic r, input int gap, input int hold);
        start_run(n, r);
        sb_q.push_back(exp_pixel(r));
        drive_pixel(gap, KTAPS);
        check_eq("latency", 128'(bus.out_valid), 128'd1);
        get_output(hold, 1'b1);
    endtask

    initial begin
        int d0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        setup_simple(16'h0000, 16'h0000, 16'h0000);
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 128'(busy), 128'd0);
        check_eq("rst_done", 128'(done), 128'd0);
        check_eq("rst_in_ready", 128'(bus.in_ready), 128'd0);
        check_eq("rst_out_valid", 128'(bus.out_valid), 128'd0);
        check_eq("rst_out_data", bus.out_data, 128'd0);
        check_eq("rst_w_addr", 128'(w_addr), 128'd0);
        rst = 1'b0;

        setup_simple(16'h0400, 16'h0400, 16'h0000);
        single_pixel(12'd1, 1'b0, 0, 0);
        check_eq("s1_ch0", 128'(last_out[15:0]), 128'h2400);
        check_eq("s1_hi", 128'(last_out[127:16]), 128'd0);

        setup_simple(16'h0400, 16'h0400, 16'hFC00);
        single_pixel(12'd1, 1'b0, 0, 0);
        check_eq("s2_bias", 128'(last_out[15:0]), 128'h2000);
        setup_simple(16'h0400, 16'h0400, 16'hD000);
        single_pixel(12'd1, 1'b1, 0, 0);
        check_eq("s2_relu", 128'(last_out[15:0]), 128'h0000);

        setup_simple(16'h1000, 16'h1000, 16'h0000);
        single_pixel(12'd1, 1'b0, 0, 0);
        check_eq("s3_sat_hi", 128'(last_out[15:0]), 128'h7FFF);
        setup_simple(16'h1000, 16'hF000, 16'h0000);
        single_pixel(12'd0, 1'b0, 0, 0);
        check_eq("s3_sat_lo", 128'(last_out[15:0]), 128'h8000);

        setup_simple(16'h0400, 16'h0400, 16'h0000);
        single_pixel(12'd1, 1'b0, 1, 5);
        check_eq("s4_ch0", 128'(last_out[15:0]), 128'h2400);

        for (int t = 0; t < KTAPS; t++)
            for (int k = 0; k < N_OUT; k++)
                wtab[t][k*48 +: 48] = {16'(64*k), 16'h0200, 16'h0400 - 16'(32*t)};
        for (int k = 0; k < N_OUT; k++) bias[k*16 +: 16] = 16'(k*100) - 16'd300;
        start_run(12'd3, 1'b0);
        for (int p = 0; p < 3; p++) begin
            for (int t = 0; t < KTAPS; t++)
                tap_in[t] = {16'(64*(t+p)), 16'(128*t) - 16'(256*p), 16'(256*(p+1))};
            sb_q.push_back(exp_pixel(1'b0));
            drive_pixel(0, KTAPS);
            check_eq("s5_latency", 128'(bus.out_valid), 128'd1);
            get_output(0, p == 2);
        end

        setup_simple(16'h0400, 16'h0400, 16'h0000);
        d0 = done_cnt;
        start_run(12'd1, 1'b0);
        drive_pixel(0, 4);
        rst = 1'b1;
        @(negedge clk);
        check_eq("s6_rst_busy", 128'(busy), 128'd0);
        check_eq("s6_rst_out", bus.out_data, 128'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("s6_no_done", 128'(done_cnt), 128'(d0));
        single_pixel(12'd1, 1'b0, 0, 0);
        check_eq("s6_ch0", 128'(last_out[15:0]), 128'h2400);
        check_eq("sb_drained", 128'(sb_q.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
